alu_pipe_core: RTL and testbench
================================

Name: alu_pipe_core

Overview:
- Parametrised, registered ALU core; next generation of the W=8 ALU.
- Adds generic width, a programmable operand-pairing timeout, a result-valid strobe and a double-width result for multiply ops.
- Sits between the operand-staging logic and the result bus; same command set and flag outputs as the existing ALU.

Parameters:
- W, 8: operand width; power of two, ≥4.
- N, 4: command width.
- TIMEOUT, 16: cycles allowed for the missing operand to arrive after a partial inp_valid.

Ports:
- clk  in  1  clock
- RST  in  1  asynchronous active-high reset
- CE  in  1  clock enable; low freezes all state
- OPA  in  W  operand A
- OPB  in  W  operand B
- Cin  in  1  carry-in
- mode  in  1  1=arithmetic, 0=logical
- inp_valid  in  2  bit0=OPA valid, bit1=OPB valid
- CMD  in  N  command
- RES  out  2W  result, zero-extended
- res_valid  out  1  one-cycle result/error strobe
- COUT  out  1  carry out
- OFLOW  out  1  borrow/overflow
- G, L, E  out  1 each  compare flags
- ERR  out  1  error, qualified by res_valid

Behaviour:
- Reset (RST=1, async): all outputs 0, FSM=IDLE, operand latches and timeout counter 0. Reset mid-wait discards latched operands.
- CE=0: no state change and outputs hold. Timeout counter does not advance.
- Commands, mode=1: 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP, 9 MUL_INC ((A+1)*(B+1)), 10 MUL_SHL ((A<<1)*B).
- Commands, mode=0: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B, 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B, 12 ROL_A_B, 13 ROR_A_B.
- Any other CMD: ERR=1, RES=0.
- Operand needs: A-only ops are INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A. B-only ops are INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B. All others need both operands.
- Latency: inputs sampled at the CE edge k; RES, flags and res_valid update at edge k+1 (one cycle); res_valid high for exactly one cycle.
- FSM states: IDLE, WAIT_A (B held, awaiting A), WAIT_B (A held, awaiting B).
- IDLE, inp_valid=11, or inp_valid meets the op's need: execute.
- IDLE, 01 with a two-operand op: latch OPA, CMD, mode, Cin; counter=0; go to WAIT_B.
- IDLE, 10 with a two-operand op: mirror case; go to WAIT_A.
- IDLE, inp_valid=00: nothing happens.
- WAIT_x, missing operand arrives (its inp_valid bit =1): execute with the latched operand, latched CMD/mode/Cin and the new operand; return to IDLE. The already-held operand is not re-sampled. New CMD is ignored while waiting.
- WAIT_x, missing operand absent: counter increments per CE cycle. When counter reaches TIMEOUT-1 without arrival: next edge gives res_valid=1, ERR=1, RES=0, flags 0; return to IDLE. Arrival on the same cycle as expiry wins (executes, no ERR).
- Arithmetic, ADD/ADD_CIN: RES[W:0]=A+B(+Cin); COUT=RES[W].
- Arithmetic, SUB/SUB_CIN: RES=A-B(-Cin) in W+1 bits; OFLOW=1 when A<B(+Cin).
- Arithmetic, INC/DEC: wrap in W bits; COUT on INC overflow; OFLOW on DEC underflow.
- Arithmetic, MUL ops: full 2W-bit result; INC wraps within W bits before the multiply.
- Flags: CMP sets G/L/E (unsigned); RES=0. All flags not defined by the op are 0.
- Rotate: amount = OPB[log2(W)-1:0]. Any higher OPB bit set gives ERR=1, RES=0.
- Logical results: zero-extended to 2W bits.

Optional Feature:
- ALU_MUL_PIPE_EN defined: MUL_INC/MUL_SHL take two cycles through an extra pipeline register; all other ops stay at one cycle.
- In-order guarantee: a one-cycle op issued the cycle after a multiply is held (not accepted) for one cycle so results never overtake.
- Input acceptance during hold: inputs are simply re-sampled next cycle; no ready output.
- Undefined: all ops are one-cycle and no hold occurs.

Decomposition:
- Package alu_pkg:
  - typedef enums for arithmetic and logical commands
  - FSM state enum
  - localparams for the A-only/B-only op sets and the rotate-amount width, $clog2(W)
- Sub-module alu_exec: purely combinational op/flag evaluation, instanced once.
- alu_pipe_core keeps the FSM, timeout counter, operand latches and output registers.

Test Plan:
- W=8, inp_valid=11, mode=1, CMD=0, OPA=8'hFF, OPB=8'h01 → next cycle RES=16'h0100, COUT=1, res_valid=1 for one cycle.
- inp_valid=01 with OPA=5, CMD=9, then idle 3 cycles, then inp_valid=10 with OPB=3 → RES=24, ERR=0, one cycle after the OPB edge.
- inp_valid=10 with OPB=7, CMD=1, then inp_valid=00 for 16 cycles → res_valid=1, ERR=1, RES=0 at cycle 16; FSM back in IDLE.
- mode=0, CMD=12, OPA=8'h81, OPB=8'h01 → RES=8'h03, ERR=0.
- Same op with OPB=8'h10 → ERR=1, RES=0.
- RST asserted mid-WAIT_B with CE toggling → all outputs 0 immediately, no res_valid after release.
- With CE=0 for 20 cycles inside WAIT_A → no timeout.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared command encodings, FSM states and operand-need tables for the registered ALU core.
// The optional two-cycle multiply path is selected with ALU_MUL_PIPE_EN.
package alu_pkg;

  typedef enum logic [3:0] {
    ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN, ARITH_SUB_CIN,
    ARITH_INC_A, ARITH_DEC_A, ARITH_INC_B, ARITH_DEC_B,
    ARITH_CMP, ARITH_MUL_INC, ARITH_MUL_SHL
  } arith_cmd_e;

  typedef enum logic [3:0] {
    LOG_AND, LOG_NAND, LOG_OR, LOG_NOR, LOG_XOR, LOG_XNOR,
    LOG_NOT_A, LOG_NOT_B, LOG_SHR1_A, LOG_SHL1_A, LOG_SHR1_B, LOG_SHL1_B,
    LOG_ROL_A_B, LOG_ROR_A_B
  } logic_cmd_e;

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_e;

  // One bit per command code; a set bit marks a single-operand op
  localparam logic [15:0] ARITH_A_ONLY = 16'h0030;
  localparam logic [15:0] ARITH_B_ONLY = 16'h00C0;
  localparam logic [15:0] LOGIC_A_ONLY = 16'h0340;
  localparam logic [15:0] LOGIC_B_ONLY = 16'h0C80;

  function automatic int rot_amt_w(input int w);
    return $clog2(w);
  endfunction

  // Returns {needs B, needs A}; unknown codes are treated as two-operand ops
  function automatic logic [1:0] op_need(input logic mode, input logic [31:0] cmd);
    logic a_only;
    logic b_only;
    if (cmd > 32'd15) return 2'b11;
    a_only = mode ? ARITH_A_ONLY[cmd[3:0]] : LOGIC_A_ONLY[cmd[3:0]];
    b_only = mode ? ARITH_B_ONLY[cmd[3:0]] : LOGIC_B_ONLY[cmd[3:0]];
    if (a_only) return 2'b01;
    if (b_only) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic is_mul(input logic mode, input logic [31:0] cmd);
    return mode && (cmd == 32'd9 || cmd == 32'd10);
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Purely combinational evaluation of one ALU command: result, carry/borrow,
// compare flags and error. No state; the core registers everything.
module alu_exec
  import alu_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [N-1:0]   cmd_i,
  input  logic           mode_i,
  input  logic           cin_i,
  output logic [2*W-1:0] res_o,
  output logic           cout_o,
  output logic           oflow_o,
  output logic           g_o,
  output logic           l_o,
  output logic           e_o,
  output logic           err_o
);

  localparam int RW = rot_amt_w(W);

  logic           cmd_ok;
  logic [3:0]     idx;
  logic [RW-1:0]  amt;
  logic           amt_hi;
  logic [2*W-1:0] rol_full;
  logic [2*W-1:0] ror_full;
  logic [W:0]     wide;
  logic [W-1:0]   narrow;
  logic [W-1:0]   a_inc;
  logic [W-1:0]   b_inc;

  assign cmd_ok   = (32'(cmd_i) < 32'd16);
  assign idx      = cmd_i[3:0];
  assign amt      = b_i[RW-1:0];
  assign amt_hi   = |(b_i >> RW);
  assign rol_full = {a_i, a_i} << amt;
  assign ror_full = {a_i, a_i} >> amt;
  assign a_inc    = a_i + W'(1);
  assign b_inc    = b_i + W'(1);

  // Sub-results land in RES[W:0] so the borrow/carry bit stays visible in the result
  always_comb begin
    res_o   = '0;
    cout_o  = 1'b0;
    oflow_o = 1'b0;
    g_o     = 1'b0;
    l_o     = 1'b0;
    e_o     = 1'b0;
    err_o   = 1'b0;
    wide    = '0;
    narrow  = '0;
    if (!cmd_ok) begin
      err_o = 1'b1;
    end else if (mode_i) begin
      case (arith_cmd_e'(idx))
        ARITH_ADD, ARITH_ADD_CIN: begin
          wide   = {1'b0, a_i} + {1'b0, b_i} +
                   ((idx == 4'(ARITH_ADD_CIN)) ? (W+1)'(cin_i) : '0);
          res_o  = {{(W-1){1'b0}}, wide};
          cout_o = wide[W];
        end
        ARITH_SUB, ARITH_SUB_CIN: begin
          wide    = {1'b0, b_i} + ((idx == 4'(ARITH_SUB_CIN)) ? (W+1)'(cin_i) : '0);
          oflow_o = ({1'b0, a_i} < wide);
          wide    = {1'b0, a_i} - wide;
          res_o   = {{(W-1){1'b0}}, wide};
        end
        ARITH_INC_A: begin res_o = {{W{1'b0}}, a_inc};          cout_o  = &a_i; end
        ARITH_DEC_A: begin res_o = {{W{1'b0}}, a_i - W'(1)};    oflow_o = ~|a_i; end
        ARITH_INC_B: begin res_o = {{W{1'b0}}, b_inc};          cout_o  = &b_i; end
        ARITH_DEC_B: begin res_o = {{W{1'b0}}, b_i - W'(1)};    oflow_o = ~|b_i; end
        ARITH_CMP: begin
          g_o = (a_i > b_i);
          l_o = (a_i < b_i);
          e_o = (a_i == b_i);
        end
        ARITH_MUL_INC: res_o = {{W{1'b0}}, a_inc} * {{W{1'b0}}, b_inc};
        ARITH_MUL_SHL: res_o = {{(W-1){1'b0}}, a_i, 1'b0} * {{W{1'b0}}, b_i};
        default:       err_o = 1'b1;
      endcase
    end else begin
      case (logic_cmd_e'(idx))
        LOG_AND:     narrow = a_i & b_i;
        LOG_NAND:    narrow = ~(a_i & b_i);
        LOG_OR:      narrow = a_i | b_i;
        LOG_NOR:     narrow = ~(a_i | b_i);
        LOG_XOR:     narrow = a_i ^ b_i;
        LOG_XNOR:    narrow = ~(a_i ^ b_i);
        LOG_NOT_A:   narrow = ~a_i;
        LOG_NOT_B:   narrow = ~b_i;
        LOG_SHR1_A:  narrow = a_i >> 1;
        LOG_SHL1_A:  narrow = a_i << 1;
        LOG_SHR1_B:  narrow = b_i >> 1;
        LOG_SHL1_B:  narrow = b_i << 1;
        LOG_ROL_A_B: if (amt_hi) err_o = 1'b1; else narrow = rol_full[2*W-1:W];
        LOG_ROR_A_B: if (amt_hi) err_o = 1'b1; else narrow = ror_full[W-1:0];
        default:     err_o = 1'b1;
      endcase
      res_o = {{W{1'b0}}, narrow};
    end
  end

endmodule

// File: rtl/alu_pipe_core.sv
// Registered ALU core: pairs split operands with a timeout, then evaluates via alu_exec.
// Define ALU_MUL_PIPE_EN to give MUL_INC/MUL_SHL an extra in-order pipeline stage.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           RST,
  input  logic           CE,
  input  logic [W-1:0]   OPA,
  input  logic [W-1:0]   OPB,
  input  logic           Cin,
  input  logic           mode,
  input  logic [1:0]     inp_valid,
  input  logic [N-1:0]   CMD,
  output logic [2*W-1:0] RES,
  output logic           res_valid,
  output logic           COUT,
  output logic           OFLOW,
  output logic           G,
  output logic           L,
  output logic           E,
  output logic           ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic [N-1:0]   lat_cmd_q, lat_cmd_d;
  logic           lat_mode_q, lat_mode_d, lat_cin_q, lat_cin_d;
  logic [2*W-1:0] res_q, res_d;
  logic           valid_q, valid_d, cout_q, cout_d, oflow_q, oflow_d;
  logic           g_q, g_d, l_q, l_d, e_q, e_d, err_q, err_d;

  logic [W-1:0]   ex_a, ex_b;
  logic [N-1:0]   ex_cmd;
  logic           ex_mode, ex_cin;
  logic [2*W-1:0] ex_res;
  logic           ex_cout, ex_oflow, ex_g, ex_l, ex_e, ex_err;
  logic [1:0]     need;
  logic           fire, tout, busy;

`ifdef ALU_MUL_PIPE_EN
  logic           mul_pend_q, mul_pend_d;
  logic [2*W-1:0] mul_res_q, mul_res_d;
  assign busy = mul_pend_q;
`else
  assign busy = 1'b0;
`endif

  alu_exec #(.W(W), .N(N)) u_exec (
    .a_i(ex_a), .b_i(ex_b), .cmd_i(ex_cmd), .mode_i(ex_mode), .cin_i(ex_cin),
    .res_o(ex_res), .cout_o(ex_cout), .oflow_o(ex_oflow),
    .g_o(ex_g), .l_o(ex_l), .e_o(ex_e), .err_o(ex_err)
  );

  assign need = op_need(mode, 32'(CMD));

  // While waiting, the held operand and the command captured with it override the live inputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_a_d    = lat_a_q;
    lat_b_d    = lat_b_q;
    lat_cmd_d  = lat_cmd_q;
    lat_mode_d = lat_mode_q;
    lat_cin_d  = lat_cin_q;
    ex_a       = OPA;
    ex_b       = OPB;
    ex_cmd     = CMD;
    ex_mode    = mode;
    ex_cin     = Cin;
    fire       = 1'b0;
    tout       = 1'b0;
    if (!busy) begin
      case (state_q)
        IDLE: begin
          if ((inp_valid & need) == need) begin
            fire = 1'b1;
          end else if (need == 2'b11 && inp_valid != 2'b00) begin
            lat_cmd_d  = CMD;
            lat_mode_d = mode;
            lat_cin_d  = Cin;
            cnt_d      = '0;
            if (inp_valid[0]) begin
              lat_a_d = OPA;
              state_d = WAIT_B;
            end else begin
              lat_b_d = OPB;
              state_d = WAIT_A;
            end
          end
        end
        WAIT_A, WAIT_B: begin
          ex_cmd  = lat_cmd_q;
          ex_mode = lat_mode_q;
          ex_cin  = lat_cin_q;
          if (state_q == WAIT_B) ex_a = lat_a_q;
          else                   ex_b = lat_b_q;
          if (inp_valid[(state_q == WAIT_B) ? 1 : 0]) begin
            fire    = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            tout    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output registers hold their last value between strobes; only res_valid pulses
  always_comb begin
    res_d   = res_q;
    cout_d  = cout_q;
    oflow_d = oflow_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;
    err_d   = err_q;
    valid_d = 1'b0;
`ifdef ALU_MUL_PIPE_EN
    mul_pend_d = 1'b0;
    mul_res_d  = mul_res_q;
    if (mul_pend_q) begin
      valid_d = 1'b1;
      res_d   = mul_res_q;
      {cout_d, oflow_d, g_d, l_d, e_d, err_d} = '0;
    end else if (fire && is_mul(ex_mode, 32'(ex_cmd))) begin
      mul_pend_d = 1'b1;
      mul_res_d  = ex_res;
    end else
`endif
    if (fire) begin
      valid_d = 1'b1;
      res_d   = ex_res;
      cout_d  = ex_cout;
      oflow_d = ex_oflow;
      g_d     = ex_g;
      l_d     = ex_l;
      e_d     = ex_e;
      err_d   = ex_err;
    end else if (tout) begin
      valid_d = 1'b1;
      res_d   = '0;
      {cout_d, oflow_d, g_d, l_d, e_d} = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_a_q    <= '0;
      lat_b_q    <= '0;
      lat_cmd_q  <= '0;
      lat_mode_q <= 1'b0;
      lat_cin_q  <= 1'b0;
      res_q      <= '0;
      valid_q    <= 1'b0;
      cout_q     <= 1'b0;
      oflow_q    <= 1'b0;
      g_q        <= 1'b0;
      l_q        <= 1'b0;
      e_q        <= 1'b0;
      err_q      <= 1'b0;
    end else if (CE) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_a_q    <= lat_a_d;
      lat_b_q    <= lat_b_d;
      lat_cmd_q  <= lat_cmd_d;
      lat_mode_q <= lat_mode_d;
      lat_cin_q  <= lat_cin_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
      cout_q     <= cout_d;
      oflow_q    <= oflow_d;
      g_q        <= g_d;
      l_q        <= l_d;
      e_q        <= e_d;
      err_q      <= err_d;
    end
  end

`ifdef ALU_MUL_PIPE_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      mul_pend_q <= 1'b0;
      mul_res_q  <= '0;
    end else if (CE) begin
      mul_pend_q <= mul_pend_d;
      mul_res_q  <= mul_res_d;
    end
  end
`endif

  assign RES       = res_q;
  assign res_valid = valid_q;
  assign COUT      = cout_q;
  assign OFLOW     = oflow_q;
  assign G         = g_q;
  assign L         = l_q;
  assign E         = e_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed + randomized bench for alu_pipe_core (default build, single-cycle multiply).
module tb_alu_pipe_core;

  localparam int W = 8;
  localparam int N = 4;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           RST, CE, Cin, mode;
  logic [W-1:0]   OPA, OPB;
  logic [1:0]     inp_valid;
  logic [N-1:0]   CMD;
  logic [2*W-1:0] RES;
  logic           res_valid, COUT, OFLOW, G, L, E, ERR;

  int nVec = 0;
  int nMis = 0;

  // Expected output state; output registers hold between strobes, so this does too
  logic [2*W-1:0] expRes;
  logic expValid, expErr, expCout, expOflow, expG, expL, expE;

  always #5 clk = ~clk;

  alu_pipe_core #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RST(RST), .CE(CE), .OPA(OPA), .OPB(OPB), .Cin(Cin), .mode(mode),
    .inp_valid(inp_valid), .CMD(CMD), .RES(RES), .res_valid(res_valid),
    .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
  );

  task automatic checkOutput(input string tag);
    logic [2*W+6:0] obs, exp_v;
    obs   = {res_valid, ERR, COUT, OFLOW, G, L, E, RES};
    exp_v = {expValid, expErr, expCout, expOflow, expG, expL, expE, expRes};
    nVec++;
    assert (obs === exp_v) else begin
      nMis++;
      $error("[TB] FAIL %s: observed {vld,err,c,o,g,l,e,res}=%h required %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] refNeed(input logic m, input int c);
    if (m && (c == 4 || c == 5)) return 2'b01;
    if (m && (c == 6 || c == 7)) return 2'b10;
    if (!m && (c == 6 || c == 8 || c == 9)) return 2'b01;
    if (!m && (c == 7 || c == 10 || c == 11)) return 2'b10;
    return 2'b11;
  endfunction

  task automatic refExec(input logic m, input int c, input int a, input int b, input logic ci);
    longint r, la, lb, mask, mask1;
    la = a; lb = b; r = 0;
    mask  = (64'd1 << W) - 1;
    mask1 = (64'd1 << (W + 1)) - 1;
    {expErr, expCout, expOflow, expG, expL, expE} = '0;
    if (m) begin
      case (c)
        0:  begin r = la + lb;      expCout = r[W]; end
        2:  begin r = la + lb + ci; expCout = r[W]; end
        1:  begin r = (la - lb) & mask1;      expOflow = (la < lb); end
        3:  begin r = (la - lb - ci) & mask1; expOflow = (la < lb + ci); end
        4:  begin r = (la + 1) & mask; expCout  = (la == mask); end
        5:  begin r = (la - 1) & mask; expOflow = (la == 0); end
        6:  begin r = (lb + 1) & mask; expCout  = (lb == mask); end
        7:  begin r = (lb - 1) & mask; expOflow = (lb == 0); end
        8:  begin expG = (la > lb); expL = (la < lb); expE = (la == lb); end
        9:  r = ((la + 1) & mask) * ((lb + 1) & mask);
        10: r = (2 * la * lb) & ((64'd1 << (2 * W)) - 1);
        default: expErr = 1'b1;
      endcase
    end else begin
      case (c)
        0:  r = la & lb;
        1:  r = ~(la & lb) & mask;
        2:  r = la | lb;
        3:  r = ~(la | lb) & mask;
        4:  r = la ^ lb;
        5:  r = ~(la ^ lb) & mask;
        6:  r = ~la & mask;
        7:  r = ~lb & mask;
        8:  r = la >> 1;
        9:  r = (la << 1) & mask;
        10: r = lb >> 1;
        11: r = (lb << 1) & mask;
        12: if (lb >= W) expErr = 1'b1; else r = ((la << lb) | (la >> (W - lb))) & mask;
        13: if (lb >= W) expErr = 1'b1; else r = ((la >> lb) | (la << (W - lb))) & mask;
        default: expErr = 1'b1;
      endcase
    end
    expRes   = r[2*W-1:0];
    expValid = 1'b1;
  endtask

  task automatic expectResult(input string tag, input logic m, input int c, input int a,
                              input int b, input logic ci);
    refExec(m, c, a, b, ci);
    checkOutput(tag);
  endtask

  task automatic expectIdle(input string tag);
    expValid = 1'b0;
    checkOutput(tag);
  endtask

  task automatic expectTimeout(input string tag);
    {expValid, expErr} = 2'b11;
    {expCout, expOflow, expG, expL, expE} = '0;
    expRes = '0;
    checkOutput(tag);
  endtask

  task automatic zeroExpected();
    {expValid, expErr, expCout, expOflow, expG, expL, expE} = '0;
    expRes = '0;
  endtask

  task automatic applyStimulus(input logic [1:0] iv, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [N-1:0] c, input logic m, input logic ci);
    inp_valid = iv; OPA = a; OPB = b; CMD = c; mode = m; Cin = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic m, ci;
    int c;
    logic [W-1:0] a, b;
    logic [1:0] iv;

    RST = 1'b1; CE = 1'b1; OPA = '0; OPB = '0; Cin = 1'b0; mode = 1'b0;
    inp_valid = 2'b00; CMD = '0;
    zeroExpected();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state");
    RST = 1'b0;

    // ADD carry-out boundary, then strobe drops while values hold
    applyStimulus(2'b11, 8'hFF, 8'h01, 4'd0, 1'b1, 1'b0);
    expectResult("add_carry", 1'b1, 0, 8'hFF, 8'h01, 1'b0);
    applyStimulus(2'b00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
    expectIdle("strobe_one_cycle");

    // Split operands: A first, B three idle cycles later; new OPA/CMD/mode must be ignored
    applyStimulus(2'b01, 8'd5, 8'd0, 4'd9, 1'b1, 1'b0);
    expectIdle("pair_wait_b");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0);
      expectIdle("pair_gap");
    end
    applyStimulus(2'b10, 8'd99, 8'd3, 4'd0, 1'b0, 1'b1);
    expectResult("pair_mul_inc", 1'b1, 9, 5, 3, 1'b0);

    // Timeout from WAIT_A fires exactly TIMEOUT edges after entry
    applyStimulus(2'b10, 8'd0, 8'd7, 4'd1, 1'b1, 1'b0);
    expectIdle("to_enter");
    for (int i = 1; i < TIMEOUT; i++) begin
      applyStimulus(2'b00, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0);
      expectIdle("to_waiting");
    end
    applyStimulus(2'b00, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0);
    expectTimeout("to_expire");
    applyStimulus(2'b11, 8'd20, 8'd30, 4'd0, 1'b1, 1'b0);
    expectResult("to_back_idle", 1'b1, 0, 20, 30, 1'b0);

    // Arrival on the expiry edge wins over the timeout
    applyStimulus(2'b01, 8'd9, 8'd0, 4'd0, 1'b1, 1'b0);
    expectIdle("race_enter");
    for (int i = 1; i < TIMEOUT; i++) begin
      applyStimulus(2'b00, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0);
      expectIdle("race_waiting");
    end
    applyStimulus(2'b10, 8'd0, 8'd4, 4'd5, 1'b1, 1'b0);
    expectResult("race_arrival_wins", 1'b1, 0, 9, 4, 1'b0);

    // Rotates and the rotate-amount range boundary
    applyStimulus(2'b11, 8'h81, 8'h01, 4'd12, 1'b0, 1'b0);
    expectResult("rol_by1", 1'b0, 12, 8'h81, 8'h01, 1'b0);
    applyStimulus(2'b11, 8'h81, 8'h10, 4'd12, 1'b0, 1'b0);
    expectResult("rol_amt_err", 1'b0, 12, 8'h81, 8'h10, 1'b0);
    applyStimulus(2'b11, 8'h81, 8'h07, 4'd12, 1'b0, 1'b0);
    expectResult("rol_by7", 1'b0, 12, 8'h81, 8'h07, 1'b0);
    applyStimulus(2'b11, 8'h81, 8'h08, 4'd13, 1'b0, 1'b0);
    expectResult("ror_amt_err", 1'b0, 13, 8'h81, 8'h08, 1'b0);

    // Undefined command codes in both modes
    applyStimulus(2'b11, 8'h12, 8'h34, 4'd11, 1'b1, 1'b0);
    expectResult("bad_arith_cmd", 1'b1, 11, 8'h12, 8'h34, 1'b0);
    applyStimulus(2'b11, 8'h12, 8'h34, 4'd15, 1'b0, 1'b0);
    expectResult("bad_logic_cmd", 1'b0, 15, 8'h12, 8'h34, 1'b0);

    // CE low holds a live strobe and ignores new inputs
    applyStimulus(2'b11, 8'h40, 8'h30, 4'd1, 1'b1, 1'b0);
    expectResult("sub_before_hold", 1'b1, 1, 8'h40, 8'h30, 1'b0);
    CE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b11, 8'h01, 8'h02, 4'd0, 1'b1, 1'b0);
      checkOutput("ce_hold_strobe");
    end
    CE = 1'b1;

    // CE low for 20 cycles in WAIT_A must not advance the timeout
    applyStimulus(2'b10, 8'd0, 8'd9, 4'd0, 1'b1, 1'b0);
    expectIdle("freeze_enter");
    CE = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(2'b00, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0);
      checkOutput("freeze_no_timeout");
    end
    CE = 1'b1;
    for (int i = 0; i < TIMEOUT - 2; i++) begin
      applyStimulus(2'b00, 8'd0, 8'd0, 4'd0, 1'b1, 1'b0);
      expectIdle("freeze_resume");
    end
    applyStimulus(2'b01, 8'd3, 8'd0, 4'd7, 1'b1, 1'b0);
    expectResult("freeze_arrival", 1'b1, 0, 3, 9, 1'b0);

    // Reset in WAIT_B while CE toggles: immediate clear, latched A discarded
    applyStimulus(2'b11, 8'h12, 8'h34, 4'd0, 1'b1, 1'b0);
    expectResult("pre_reset_add", 1'b1, 0, 8'h12, 8'h34, 1'b0);
    applyStimulus(2'b01, 8'h55, 8'h00, 4'd0, 1'b1, 1'b0);
    expectIdle("rst_wait_b");
    CE = 1'b0;
    applyStimulus(2'b00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
    checkOutput("rst_ce_low");
    CE = 1'b1;
    applyStimulus(2'b00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
    expectIdle("rst_ce_high");
    CE = 1'b0;
    RST = 1'b1;
    #1;
    zeroExpected();
    checkOutput("rst_async_clear");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
      checkOutput("rst_held");
    end
    RST = 1'b0;
    CE = 1'b1;
    applyStimulus(2'b10, 8'h00, 8'h22, 4'd0, 1'b1, 1'b0);
    expectIdle("rst_latch_discarded");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b00, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
      expectIdle("rst_no_strobe");
    end
    applyStimulus(2'b01, 8'h10, 8'h00, 4'd3, 1'b1, 1'b0);
    expectResult("rst_new_pair", 1'b1, 0, 8'h10, 8'h22, 1'b0);

    // Randomized single-step commands against the arithmetic reference
    for (int i = 0; i < 300; i++) begin
      m  = 1'($urandom_range(0, 1));
      c  = m ? $urandom_range(0, 12) : $urandom_range(0, 15);
      a  = W'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, W - 1)) : W'($urandom);
      ci = 1'($urandom_range(0, 1));
      iv = ($urandom_range(0, 3) == 0) ? refNeed(m, c) : 2'b11;
      applyStimulus(iv, a, b, N'(c), m, ci);
      expectResult("random_op", m, c, a, b, ci);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
